multi_two_to_one_mux_arb: RTL



---
 rtl/multi_two_to_one_mux_arb.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/multi_two_to_one_mux_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_two_to_one_mux_arb                                                 |
// | Two-client round-robin merge onto a single-port memory, read data routed |
// | back by tag. MULTI_MUX_FIXED_PRIO_EN: client 1 always wins, no pointer.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multi_two_to_one_mux_arb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              req2,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data2,
  output logic              gnt2,
  output logic              rvalid2,
  output logic [DATA_W-1:0] rdata2,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic grant1;
  logic grant2;
  logic accept;

  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_id_q,    mem_id_d;

  logic [MEM_LAT-1:0] tag_v_q,  tag_v_d;
  logic [MEM_LAT-1:0] tag_id_q, tag_id_d;

  logic              rvalid1_q, rvalid1_d;
  logic              rvalid2_q, rvalid2_d;
  logic [DATA_W-1:0] rdata1_q,  rdata1_d;
  logic [DATA_W-1:0] rdata2_q,  rdata2_d;

`ifndef MULTI_MUX_FIXED_PRIO_EN
  // 0: client 1 wins a tie, 1: client 2 wins a tie
  logic ptr_q, ptr_d;
`endif

  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (rst_n) begin
`ifdef MULTI_MUX_FIXED_PRIO_EN
      grant1 = req1;
      grant2 = req2 && !req1;
`else
      grant1 = req1 && (!req2 || !ptr_q);
      grant2 = req2 && (!req1 ||  ptr_q);
`endif
    end
  end

  assign accept = grant1 || grant2;

`ifndef MULTI_MUX_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    mem_en_d    = accept;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_id_d    = mem_id_q;
    if (grant1) begin
      mem_we_d    = we1;
      mem_addr_d  = addr1;
      mem_wdata_d = data1;
      mem_id_d    = 1'b0;
    end else if (grant2) begin
      mem_we_d    = we2;
      mem_addr_d  = addr2;
      mem_wdata_d = data2;
      mem_id_d    = 1'b1;
    end
  end

  // Tag enters from the memory stage so stage MEM_LAT-1 lines up with mem_rdata
  always_comb begin
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    tag_v_d[0]  = mem_en_q && !mem_we_q;
    tag_id_d[0] = mem_id_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  always_comb begin
    rvalid1_d = tag_v_q[MEM_LAT-1] && !tag_id_q[MEM_LAT-1];
    rvalid2_d = tag_v_q[MEM_LAT-1] &&  tag_id_q[MEM_LAT-1];
    rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
    rdata2_d  = rvalid2_d ? mem_rdata : rdata2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_id_q    <= 1'b0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      rvalid1_q   <= 1'b0;
      rvalid2_q   <= 1'b0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_id_q    <= mem_id_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      rvalid1_q   <= rvalid1_d;
      rvalid2_q   <= rvalid2_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
    end
  end

  assign gnt1      = grant1;
  assign gnt2      = grant2;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid1   = rvalid1_q;
  assign rvalid2   = rvalid2_q;
  assign rdata1    = rdata1_q;
  assign rdata2    = rdata2_q;

endmodule
`default_nettype wire
